mmio_leds_pwm: RTL and testbench



---
 rtl/mmio_pkg.sv | 15 +
 rtl/pwm_channel.sv | 43 ++++
 rtl/mmio_leds_pwm.sv | 166 ++++++++++++++++
 tb/tb_mmio_leds_pwm.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO LED/PWM peripheral: register word indices
// and the layout of the per-channel CH register.
package mmio_pkg;

   localparam int W_CTRL          = 32;
   localparam int W_BLINK_HALF    = 33;
   localparam int W_PINS          = 34;

   localparam int CH_DUTY_LSB     = 0;
   localparam int CH_DUTY_MAX_W   = 16;
   localparam int CH_BLINK_EN_BIT = 16;

   localparam int CTRL_ENABLE_BIT = 0;

endpackage

// File: rtl/pwm_channel.sv
// One LED channel: holds its duty and blink-enable settings and compares the
// duty against the shared PWM counter to produce the raw (pre-gate) on state.
module pwm_channel
#(
   parameter int PWM_BITS = 8
)
(
   input  logic                sys_clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [PWM_BITS-1:0] wr_duty,
   input  logic                wr_blink_en,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   output logic [31:0]         reg_word,
   output logic                blink_en,
   output logic                raw_on
);
   import mmio_pkg::*;

   logic [PWM_BITS-1:0] duty;

   // Channel settings register, loaded only on a committed write to this channel.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         duty     <= '0;
         blink_en <= 1'b0;
      end else if (wr_en) begin
         duty     <= wr_duty;
         blink_en <= wr_blink_en;
      end
   end

   // Readback view of the CH register; unused bits read as zero.
   always_comb begin
      reg_word = '0;
      reg_word[CH_DUTY_LSB +: PWM_BITS] = duty;
      reg_word[CH_BLINK_EN_BIT] = blink_en;
   end

   // All-ones duty is forced fully on so the top code is not lost to the compare.
   assign raw_on = (duty == '1) || (pwm_cnt < duty);

endmodule

// File: rtl/mmio_leds_pwm.sv
// MMIO peripheral driving NUM_LEDS outputs, each with a PWM duty and an
// optional blink gate from a shared programmable blink timer. Uses the
// two-cycle work/done handshake of the other MMIO peripherals.
module mmio_leds_pwm
#(
   parameter logic [31:0] BASE_ADDR     = 32'hFFFF0100,
   parameter int          ADDR_BITS     = 8,
   parameter int          NUM_LEDS      = 24,
   parameter int          PWM_BITS      = 8,
   parameter int          BLINK_BITS    = 24,
   parameter logic [31:0] BLINK_DEFAULT = 32'd5_000_000
)
(
   input  logic                sys_clk,
   input  logic                rst,
   input  logic                mmio_read,
   input  logic                mmio_write,
   input  logic [31:0]         mmio_addr,
   input  logic [31:0]         mmio_write_data,
   output logic                mmio_work,
   output logic                mmio_done,
   output logic [31:0]         mmio_read_data,
   output logic [NUM_LEDS-1:0] leds_pin
);
   import mmio_pkg::*;

   localparam int WIDX_BITS = ADDR_BITS - 2;

   logic                  in_window;
   logic [WIDX_BITS-1:0]  word_idx;
   logic                  accept;
   logic                  commit;
   logic                  wr_ctrl;
   logic                  wr_blink;

   logic                  enable;
   logic [BLINK_BITS-1:0] blink_half;
   logic [BLINK_BITS-1:0] blink_cnt;
   logic                  blink_phase;
   logic [PWM_BITS-1:0]   pwm_cnt;

   logic [31:0]           ch_word [NUM_LEDS];
   logic [NUM_LEDS-1:0]   raw_on;
   logic [NUM_LEDS-1:0]   blink_en;

   logic [31:0]           pins_ext;
   logic [31:0]           half_ext;
   logic [31:0]           rd_value;

   logic                  unused_bits;

   assign in_window = (mmio_addr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);
   assign word_idx  = mmio_addr[ADDR_BITS-1:2];
   assign mmio_work = in_window & (mmio_read | mmio_write);

   // A request is taken only while done is low, so a held strobe commits once per two cycles.
   assign accept    = mmio_work & ~mmio_done;
   assign commit    = accept & mmio_write;
   assign wr_ctrl   = commit && (word_idx == WIDX_BITS'(W_CTRL));
   assign wr_blink  = commit && (word_idx == WIDX_BITS'(W_BLINK_HALF));

   assign unused_bits = &{1'b0, mmio_addr[1:0], mmio_write_data};

   for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
      pwm_channel #(
         .PWM_BITS    (PWM_BITS)
      ) u_ch (
         .sys_clk     (sys_clk),
         .rst         (rst),
         .wr_en       (commit && (word_idx == WIDX_BITS'(g))),
         .wr_duty     (mmio_write_data[CH_DUTY_LSB +: PWM_BITS]),
         .wr_blink_en (mmio_write_data[CH_BLINK_EN_BIT]),
         .pwm_cnt     (pwm_cnt),
         .reg_word    (ch_word[g]),
         .blink_en    (blink_en[g]),
         .raw_on      (raw_on[g])
      );
   end

   // Register read mux; anything unmapped reads as zero.
   always_comb begin
      pins_ext = '0;
      half_ext = '0;
      rd_value = '0;
      pins_ext[NUM_LEDS-1:0]   = leds_pin;
      half_ext[BLINK_BITS-1:0] = blink_half;
      for (int i = 0; i < NUM_LEDS; i++) begin
         if (word_idx == WIDX_BITS'(i)) begin
            rd_value = ch_word[i];
         end
      end
      if (word_idx == WIDX_BITS'(W_CTRL)) begin
         rd_value[CTRL_ENABLE_BIT] = enable;
      end
      if (word_idx == WIDX_BITS'(W_BLINK_HALF)) begin
         rd_value = half_ext;
      end
      if (word_idx == WIDX_BITS'(W_PINS)) begin
         rd_value = pins_ext;
      end
   end

   // Handshake: one-cycle done pulse carrying the pre-write register value.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         mmio_done      <= 1'b0;
         mmio_read_data <= '0;
      end else begin
         mmio_done      <= accept;
         mmio_read_data <= accept ? rd_value : '0;
      end
   end

   // CTRL and BLINK_HALF configuration registers.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         enable     <= 1'b1;
         blink_half <= BLINK_DEFAULT[BLINK_BITS-1:0];
      end else begin
         if (wr_ctrl) begin
            enable <= mmio_write_data[CTRL_ENABLE_BIT];
         end
         if (wr_blink) begin
            blink_half <= mmio_write_data[BLINK_BITS-1:0];
         end
      end
   end

   // Free-running PWM counter shared by all channels.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
   end

   // Blink timer: half-period down-counter toggling the phase; a zero half-period parks it on.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         blink_cnt   <= BLINK_DEFAULT[BLINK_BITS-1:0];
         blink_phase <= 1'b1;
      end else if (wr_blink) begin
         blink_cnt   <= mmio_write_data[BLINK_BITS-1:0];
         blink_phase <= 1'b1;
      end else if (blink_half == '0) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (blink_cnt == '0) begin
         blink_cnt   <= blink_half;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt - BLINK_BITS'(1);
      end
   end

   // Registered LED drive: global enable, PWM compare and per-channel blink gate.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         leds_pin <= '0;
      end else begin
         leds_pin <= {NUM_LEDS{enable}} & raw_on & (~blink_en | {NUM_LEDS{blink_phase}});
      end
   end

endmodule

// File: tb/tb_mmio_leds_pwm.sv
// Self-checking bench for mmio_leds_pwm: directed scenarios plus randomized
// MMIO traffic, compared every cycle against a behavioural model.
module tb_mmio_leds_pwm;

   localparam logic [31:0] BASE       = 32'hFFFF0100;
   localparam int          NUM        = 24;
   localparam int          PWM_BITS   = 8;
   localparam int          BLINK_BITS = 24;
   localparam logic [31:0] BLINK_DEF  = 32'd5_000_000;

   logic           sys_clk;
   logic           rst;
   logic           mmio_read;
   logic           mmio_write;
   logic [31:0]    mmio_addr;
   logic [31:0]    mmio_write_data;
   logic           mmio_work;
   logic           mmio_done;
   logic [31:0]    mmio_read_data;
   logic [NUM-1:0] leds_pin;

   mmio_leds_pwm #(
      .BASE_ADDR       (BASE),
      .ADDR_BITS       (8),
      .NUM_LEDS        (NUM),
      .PWM_BITS        (PWM_BITS),
      .BLINK_BITS      (BLINK_BITS),
      .BLINK_DEFAULT   (BLINK_DEF)
   ) dut (
      .sys_clk         (sys_clk),
      .rst             (rst),
      .mmio_read       (mmio_read),
      .mmio_write      (mmio_write),
      .mmio_addr       (mmio_addr),
      .mmio_write_data (mmio_write_data),
      .mmio_work       (mmio_work),
      .mmio_done       (mmio_done),
      .mmio_read_data  (mmio_read_data),
      .leds_pin        (leds_pin)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int tests_run    = 0;
   int tests_failed = 0;

   // Single comparison point: counts and reports every check.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", tag, actual, expected, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   int          m_duty [NUM];
   bit          m_en   [NUM];
   bit          m_enable;
   longint      m_half;
   longint      k_pwm;
   longint      k_blink;
   logic [31:0] exp_pins;
   bit          exp_done;
   logic [31:0] exp_rdata;
   bit          model_valid = 1'b0;

   function automatic bit inWindow(input logic [31:0] a);
      return (a & 32'hFFFFFF00) == BASE;
   endfunction

   function automatic int wordOf(input logic [31:0] a);
      return int'((a >> 2) & 32'h3F);
   endfunction

   function automatic logic [31:0] wa(input int w);
      return BASE + 32'(w * 4);
   endfunction

   // Blink phase from the cycles elapsed since the timer was last (re)loaded.
   function automatic bit blinkPhase();
      if (m_half == 0) return 1'b1;
      return ((k_blink / (m_half + 1)) % 2) == 0;
   endfunction

   function automatic logic [31:0] modelRead(input int w);
      if (w < NUM)           return (m_en[w] ? 32'h0001_0000 : 32'h0) | 32'(m_duty[w]);
      if (w == 32)           return {31'b0, m_enable};
      if (w == 33)           return 32'(m_half);
      if (w == 34)           return exp_pins;
      return 32'h0;
   endfunction

   // Model advances on each clock edge using the values in force before the edge.
   always @(posedge sys_clk) begin : model
      logic [31:0] next_pins;
      bit          raw;
      bit          blink_wr;
      int          w;
      if (rst) begin
         for (int i = 0; i < NUM; i++) begin
            m_duty[i] = 0;
            m_en[i]   = 1'b0;
         end
         m_enable    = 1'b1;
         m_half      = longint'(BLINK_DEF);
         k_pwm       = 0;
         k_blink     = 0;
         exp_pins    = '0;
         exp_done    = 1'b0;
         exp_rdata   = '0;
         model_valid = 1'b1;
      end else begin
         next_pins = '0;
         for (int i = 0; i < NUM; i++) begin
            raw = (m_duty[i] == 255) || (int'(k_pwm % 256) < m_duty[i]);
            if (m_enable && raw && (!m_en[i] || blinkPhase())) next_pins[i] = 1'b1;
         end
         blink_wr = 1'b0;
         if (inWindow(mmio_addr) && (mmio_read || mmio_write) && !exp_done) begin
            w         = wordOf(mmio_addr);
            exp_rdata = modelRead(w);
            exp_done  = 1'b1;
            if (mmio_write) begin
               if (w < NUM) begin
                  m_duty[w] = int'(mmio_write_data & 32'hFF);
                  m_en[w]   = mmio_write_data[16];
               end else if (w == 32) begin
                  m_enable = mmio_write_data[0];
               end else if (w == 33) begin
                  m_half   = longint'(mmio_write_data & 32'h00FF_FFFF);
                  blink_wr = 1'b1;
               end
            end
         end else begin
            exp_done  = 1'b0;
            exp_rdata = '0;
         end
         exp_pins = next_pins;
         k_pwm++;
         if (blink_wr) k_blink = 0;
         else          k_blink++;
      end
   end

   // Cycle-by-cycle comparison, sampled mid-cycle.
   always @(negedge sys_clk) begin
      if (model_valid) begin
         checkOutput("leds_pin", {8'b0, leds_pin}, exp_pins);
         checkOutput("mmio_done", {31'b0, mmio_done}, {31'b0, exp_done});
         checkOutput("mmio_read_data", mmio_read_data, exp_rdata);
         checkOutput("mmio_work", {31'b0, mmio_work},
                     {31'b0, inWindow(mmio_addr) && (mmio_read || mmio_write)});
      end
   end

   // ---------------- stimulus ----------------
   task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data);
      @(posedge sys_clk);
      #2;
      mmio_read       = rd;
      mmio_write      = wr;
      mmio_addr       = addr;
      mmio_write_data = data;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic doAccess(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                           output logic [31:0] rdata);
      bit seen = 1'b0;
      rdata = '0;
      applyStimulus(rd, wr, addr, data);
      for (int n = 0; n < 4 && !seen; n++) begin
         @(posedge sys_clk);
         #2;
         if (mmio_done) begin
            seen  = 1'b1;
            rdata = mmio_read_data;
         end
      end
      mmio_read  = 1'b0;
      mmio_write = 1'b0;
      if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic doReset();
      @(posedge sys_clk);
      #2;
      rst = 1'b1;
      mmio_read = 1'b0;
      mmio_write = 1'b0;
      repeat (2) @(posedge sys_clk);
      #2;
      rst = 1'b0;
   endtask

   logic [31:0] r;
   int          c3, c5, cother, off_len, on_len, held;
   bit          prev, found;

   initial begin
      rst = 1'b1;
      mmio_read = 1'b0;
      mmio_write = 1'b0;
      mmio_addr = 32'h0;
      mmio_write_data = 32'h0;
      doReset();

      // Reset values read back through the bus.
      doAccess(1'b1, 1'b0, wa(0), 32'h0, r);
      checkOutput("rst_ch0", r, 32'h0);
      doAccess(1'b1, 1'b0, wa(32), 32'h0, r);
      checkOutput("rst_ctrl", r, 32'h1);
      doAccess(1'b1, 1'b0, wa(33), 32'h0, r);
      checkOutput("rst_blink_half", r, BLINK_DEF);
      @(posedge sys_clk);
      #2;
      checkOutput("done_one_cycle", {31'b0, mmio_done}, 32'h0);
      checkOutput("rdata_cleared", mmio_read_data, 32'h0);

      // Full-on and quarter-duty channels.
      doAccess(1'b0, 1'b1, wa(3), 32'hFF, r);
      doAccess(1'b0, 1'b1, wa(5), 32'h40, r);
      idle(2);
      c3 = 0; c5 = 0; cother = 0;
      for (int n = 0; n < 256; n++) begin
         @(negedge sys_clk);
         if (leds_pin[3]) c3++;
         if (leds_pin[5]) c5++;
         if ((leds_pin & ~24'h28) != 0) cother++;
      end
      checkOutput("pin3_on_count", 32'(c3), 32'd256);
      checkOutput("pin5_on_count", 32'(c5), 32'd64);
      checkOutput("other_pins_on", 32'(cother), 32'd0);

      // Blinking channel with half-period 10.
      doAccess(1'b0, 1'b1, wa(33), 32'd10, r);
      doAccess(1'b0, 1'b1, wa(2), 32'h0001_00FF, r);
      @(negedge sys_clk);
      prev = leds_pin[2];
      found = 1'b0;
      for (int n = 0; n < 60 && !found; n++) begin
         @(negedge sys_clk);
         if (prev && !leds_pin[2]) found = 1'b1;
         prev = leds_pin[2];
      end
      if (!found) checkOutput("blink_fall_timeout", 32'd0, 32'd1);
      off_len = 1;
      for (int n = 0; n < 60; n++) begin
         @(negedge sys_clk);
         if (leds_pin[2]) break;
         off_len++;
      end
      on_len = 1;
      for (int n = 0; n < 60; n++) begin
         @(negedge sys_clk);
         if (!leds_pin[2]) break;
         on_len++;
      end
      checkOutput("blink_off_len", 32'(off_len), 32'd11);
      checkOutput("blink_on_len", 32'(on_len), 32'd11);

      // Zero half-period parks the blink phase on.
      doAccess(1'b0, 1'b1, wa(33), 32'd0, r);
      idle(2);
      held = 0;
      for (int n = 0; n < 30; n++) begin
         @(negedge sys_clk);
         if (leds_pin[2]) held++;
      end
      checkOutput("blink_zero_held_on", 32'(held), 32'd30);

      // Write strobe held four cycles: first and third values commit.
      applyStimulus(1'b0, 1'b1, wa(1), 32'h11);
      applyStimulus(1'b0, 1'b1, wa(1), 32'h22);
      applyStimulus(1'b0, 1'b1, wa(1), 32'h33);
      applyStimulus(1'b0, 1'b1, wa(1), 32'h44);
      idle(2);
      doAccess(1'b1, 1'b0, wa(1), 32'h0, r);
      checkOutput("held_write_ch1", r, 32'h33);

      // Just below the window: ignored entirely.
      applyStimulus(1'b1, 1'b0, BASE - 32'd4, 32'h0);
      @(negedge sys_clk);
      checkOutput("below_window_work", {31'b0, mmio_work}, 32'h0);
      repeat (2) begin
         @(negedge sys_clk);
         checkOutput("below_window_done", {31'b0, mmio_done}, 32'h0);
      end
      idle(1);

      // Unmapped words: acknowledged, read zero, writes ignored.
      doAccess(1'b1, 1'b0, wa(40), 32'h0, r);
      checkOutput("w40_read", r, 32'h0);
      doAccess(1'b0, 1'b1, wa(40), 32'hFFFF_FFFF, r);
      doAccess(1'b0, 1'b1, wa(30), 32'hFFFF_FFFF, r);
      doAccess(1'b1, 1'b0, wa(30), 32'h0, r);
      checkOutput("w30_read", r, 32'h0);
      doAccess(1'b1, 1'b0, wa(32), 32'h0, r);
      checkOutput("ctrl_after_unmapped", r, 32'h1);

      // Reset lands on the commit edge of a CTRL=0 write.
      @(posedge sys_clk);
      #2;
      rst = 1'b1;
      mmio_write = 1'b1;
      mmio_addr = wa(32);
      mmio_write_data = 32'h0;
      @(posedge sys_clk);
      #2;
      rst = 1'b0;
      mmio_write = 1'b0;
      @(negedge sys_clk);
      checkOutput("done_after_rst", {31'b0, mmio_done}, 32'h0);
      doAccess(1'b1, 1'b0, wa(32), 32'h0, r);
      checkOutput("ctrl_after_rst", r, 32'h1);

      // Randomized traffic checked by the model.
      for (int t = 0; t < 300; t++) begin
         int          w;
         int          kind;
         logic [31:0] a;
         logic [31:0] d;
         w    = $urandom_range(0, 47);
         kind = $urandom_range(0, 2);
         a    = BASE + 32'(w * 4) + 32'($urandom_range(0, 3));
         d    = $urandom;
         if (w == 33) d = 32'($urandom_range(0, 12));
         if (w == 32 && $urandom_range(0, 3) != 0) d = 32'h1;
         if ($urandom_range(0, 9) == 0) begin
            a = BASE ^ (32'h100 << $urandom_range(0, 23));
            applyStimulus(kind != 1, kind != 0, a, d);
            idle(2);
         end else begin
            doAccess(kind != 1, kind != 0, a, d, r);
         end
         idle($urandom_range(0, 3));
      end
      idle(3);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
